// File: rtl/hubris_mem_pkg.sv
// Shared types for the Hubris memory arbiter: read-response owner IDs,
// the tag carried alongside each in-flight read, and the byte-enable width
// of the default 32-bit data path.
package hubris_mem_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BYTE_EN_WIDTH      = DEFAULT_DATA_WIDTH / 8;

  typedef enum logic {
    OWNER_DATA  = 1'b0,
    OWNER_FETCH = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

endpackage

// File: rtl/hubris_mem_arbiter_if.sv
// Bundle of the data-port, fetch-port and memory-port signals seen by the
// Hubris memory arbiter. The arbiter uses the slave view; the core/memory
// side (or a bench) uses the master view.
interface hubris_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  d_req;
  logic [BE_WIDTH-1:0]   d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  f_req;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_gnt;
  logic                  f_rvalid;
  logic [DATA_WIDTH-1:0] f_rdata;

  logic                  mem_en;
  logic [BE_WIDTH-1:0]   mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  logic                  fetch_stalled;

  modport slave (
    input  d_req, d_we, d_addr, d_wdata,
    input  f_req, f_addr,
    input  mem_dout,
    output d_gnt, d_rvalid, d_rdata,
    output f_gnt, f_rvalid, f_rdata,
    output mem_en, mem_we, mem_addr, mem_din,
    output fetch_stalled
  );

  modport master (
    output d_req, d_we, d_addr, d_wdata,
    output f_req, f_addr,
    output mem_dout,
    input  d_gnt, d_rvalid, d_rdata,
    input  f_gnt, f_rvalid, f_rdata,
    input  mem_en, mem_we, mem_addr, mem_din,
    input  fetch_stalled
  );

endinterface

// File: rtl/hubris_mem_resp_tracker.sv
// Read-response tracker: a READ_LATENCY-deep shift register of owner tags
// that lines up with the memory's read pipeline, and steers mem_dout to
// whichever requester issued the read. Non-owning rdata is held at zero.
module hubris_mem_resp_tracker
  import hubris_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  tag_t                  tag_in,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata
);

  tag_t tag_pipe [READ_LATENCY];
  tag_t tag_out;

  // Shift a tag in every cycle; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign tag_out = tag_pipe[READ_LATENCY-1];

  // Route the memory word to the tag's owner; nothing is reported during reset
  always_comb begin
    d_rvalid = 1'b0;
    f_rvalid = 1'b0;
    d_rdata  = '0;
    f_rdata  = '0;
    if (!reset && tag_out.valid) begin
      if (tag_out.owner == OWNER_DATA) begin
        d_rvalid = 1'b1;
        d_rdata  = mem_dout;
      end else begin
        f_rvalid = 1'b1;
        f_rdata  = mem_dout;
      end
    end
  end

endmodule

// File: rtl/hubris_mem_arbiter.sv
// Two-requester arbiter sharing one single-port synchronous memory between
// the Hubris data path and the instruction fetch unit. Data has priority.
// Optional build macro HUBRIS_ARB_STARVATION_GUARD_EN adds a streak counter
// that hands the port to fetch after MAX_DATA_STREAK consecutive data wins.
module hubris_mem_arbiter
  import hubris_mem_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int READ_LATENCY    = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input logic                 clk,
  input logic                 reset,
  hubris_mem_arbiter_if.slave bus
);

  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
    $error("hubris_mem_arbiter: READ_LATENCY must be 1 or 2");
  end
  if (MAX_DATA_STREAK < 1) begin : g_bad_streak
    $error("hubris_mem_arbiter: MAX_DATA_STREAK must be at least 1");
  end
  if (ADDR_WIDTH < 2 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("hubris_mem_arbiter: unsupported address/data width");
  end

  logic d_gnt;
  logic f_gnt;
  logic fetch_priority;
  logic d_is_read;
  tag_t push_tag;

`ifdef HUBRIS_ARB_STARVATION_GUARD_EN
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;

  assign fetch_priority = bus.f_req && (streak_q == STREAK_MAX);

  // Count data wins that kept a waiting fetch out; saturate at the limit
  always_comb begin
    streak_d = streak_q;
    if (!bus.f_req || f_gnt) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Streak counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign fetch_priority = 1'b0;
`endif

  // Grant decision: data first unless fetch has been starved long enough
  always_comb begin
    d_gnt = 1'b0;
    f_gnt = 1'b0;
    if (!reset) begin
      if (bus.d_req && !fetch_priority) begin
        d_gnt = 1'b1;
      end else if (bus.f_req) begin
        f_gnt = 1'b1;
      end
    end
  end

  assign d_is_read = (bus.d_we == '0);

  // Drive the memory port from the winner and build the response tag
  always_comb begin
    bus.mem_en     = 1'b0;
    bus.mem_we     = '0;
    bus.mem_addr   = '0;
    bus.mem_din    = '0;
    push_tag.valid = 1'b0;
    push_tag.owner = OWNER_DATA;
    if (d_gnt) begin
      bus.mem_en     = 1'b1;
      bus.mem_we     = bus.d_we;
      bus.mem_addr   = bus.d_addr;
      bus.mem_din    = bus.d_wdata;
      push_tag.valid = d_is_read;
      push_tag.owner = OWNER_DATA;
    end else if (f_gnt) begin
      bus.mem_en     = 1'b1;
      bus.mem_addr   = bus.f_addr;
      push_tag.valid = 1'b1;
      push_tag.owner = OWNER_FETCH;
    end
  end

  assign bus.d_gnt         = d_gnt;
  assign bus.f_gnt         = f_gnt;
  assign bus.fetch_stalled = !reset && bus.f_req && !f_gnt;

  logic                  d_rvalid;
  logic                  f_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic [DATA_WIDTH-1:0] f_rdata;

  hubris_mem_resp_tracker #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_resp_tracker (
    .clk      (clk),
    .reset    (reset),
    .tag_in   (push_tag),
    .mem_dout (bus.mem_dout),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata)
  );

  assign bus.d_rvalid = d_rvalid;
  assign bus.d_rdata  = d_rdata;
  assign bus.f_rvalid = f_rvalid;
  assign bus.f_rdata  = f_rdata;

endmodule

// File: tb/tb_hubris_mem_arbiter.sv
// Bench for hubris_mem_arbiter. One instance uses READ_LATENCY=1 and is
// driven from a cycle-by-cycle vector table; a second uses READ_LATENCY=2
// for the latency and reset-mid-read sequences. Behavioural BRAMs with word
// i preloaded to value i sit behind each memory port.
module tb_hubris_mem_arbiter;
  import hubris_mem_pkg::*;

  logic clk = 1'b0;
  logic reset1;
  logic reset2;
  int   tests = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hubris_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  hubris_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

  hubris_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(1), .MAX_DATA_STREAK(4)
  ) u_dut1 (
    .clk   (clk),
    .reset (reset1),
    .bus   (bus1)
  );

  hubris_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(2), .MAX_DATA_STREAK(4)
  ) u_dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  logic [31:0] mem1 [256];
  logic [31:0] rd1;
  logic [31:0] mem2 [256];
  logic [31:0] rd2a;
  logic [31:0] rd2b;

  // Single-cycle BRAM model behind instance 1; preloads while reset1 is high
  always @(posedge clk) begin
    if (reset1) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 32'(i);
      rd1 <= '0;
    end else if (bus1.mem_en) begin
      if (bus1.mem_we == '0) rd1 <= mem1[bus1.mem_addr[9:2]];
      for (int b = 0; b < 4; b++) begin
        if (bus1.mem_we[b]) mem1[bus1.mem_addr[9:2]][8*b +: 8] <= bus1.mem_din[8*b +: 8];
      end
    end
  end
  assign bus1.mem_dout = rd1;

  // Two-cycle BRAM model behind instance 2
  always @(posedge clk) begin
    if (reset2) begin
      for (int i = 0; i < 256; i++) mem2[i] <= 32'(i);
      rd2a <= '0;
    end else if (bus2.mem_en && bus2.mem_we == '0) begin
      rd2a <= mem2[bus2.mem_addr[9:2]];
    end
    rd2b <= rd2a;
  end
  assign bus2.mem_dout = rd2b;

  typedef struct {
    logic                     d_req;
    logic [BYTE_EN_WIDTH-1:0] d_we;
    logic [31:0]              d_addr;
    logic [31:0]              d_wdata;
    logic                     f_req;
    logic [31:0]              f_addr;
    logic                     e_d_gnt;
    logic                     e_f_gnt;
    logic                     e_mem_en;
    logic [BYTE_EN_WIDTH-1:0] e_mem_we;
    logic [31:0]              e_mem_addr;
    logic [31:0]              e_mem_din;
    logic                     e_stall;
    logic                     e_d_rvalid;
    logic [31:0]              e_d_rdata;
    logic                     e_f_rvalid;
    logic [31:0]              e_f_rdata;
  } vec_t;

  localparam int NUM_VECS = 14;
  vec_t vecs [NUM_VECS];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    bus1.d_req   = v.d_req;
    bus1.d_we    = v.d_we;
    bus1.d_addr  = v.d_addr;
    bus1.d_wdata = v.d_wdata;
    bus1.f_req   = v.f_req;
    bus1.f_addr  = v.f_addr;
  endtask

  task automatic drive1(input logic dreq, input logic [31:0] daddr,
                        input logic freq, input logic [31:0] faddr);
    @(posedge clk);
    #1;
    bus1.d_req   = dreq;
    bus1.d_we    = '0;
    bus1.d_addr  = daddr;
    bus1.d_wdata = '0;
    bus1.f_req   = freq;
    bus1.f_addr  = faddr;
  endtask

  initial begin
    logic exp_d;
    logic prev_d;
    logic prev_f;
    logic guard;

`ifdef HUBRIS_ARB_STARVATION_GUARD_EN
    guard = 1'b1;
`else
    guard = 1'b0;
`endif

    // d_req d_we addr wdata f_req f_addr | dg fg en we maddr mdin st | drv drd frv frd
    vecs[0]  = '{0, 4'h0, 32'h0,   32'h0,        1, 32'h0,   0, 1, 1, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 32'h0};
    vecs[1]  = '{0, 4'h0, 32'h0,   32'h0,        1, 32'h4,   0, 1, 1, 4'h0, 32'h4,   32'h0,        0, 0, 32'h0,        1, 32'h0};
    vecs[2]  = '{0, 4'h0, 32'h0,   32'h0,        1, 32'h8,   0, 1, 1, 4'h0, 32'h8,   32'h0,        0, 0, 32'h0,        1, 32'h1};
    vecs[3]  = '{0, 4'hF, 32'h200, 32'h55,       0, 32'h300, 0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        1, 32'h2};
    vecs[4]  = '{0, 4'h0, 32'h0,   32'h0,        0, 32'h0,   0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        0, 32'h0};
    vecs[5]  = '{1, 4'hF, 32'h100, 32'hDEADBEEF, 0, 32'h0,   1, 0, 1, 4'hF, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h0};
    vecs[6]  = '{1, 4'h0, 32'h100, 32'h0,        0, 32'h0,   1, 0, 1, 4'h0, 32'h100, 32'h0,        0, 0, 32'h0,        0, 32'h0};
    vecs[7]  = '{0, 4'h0, 32'h0,   32'h0,        0, 32'h0,   0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h0};
    vecs[8]  = '{1, 4'h4, 32'h104, 32'h00AB0000, 0, 32'h0,   1, 0, 1, 4'h4, 32'h104, 32'h00AB0000, 0, 0, 32'h0,        0, 32'h0};
    vecs[9]  = '{1, 4'h0, 32'h104, 32'h0,        0, 32'h0,   1, 0, 1, 4'h0, 32'h104, 32'h0,        0, 0, 32'h0,        0, 32'h0};
    vecs[10] = '{0, 4'h0, 32'h0,   32'h0,        0, 32'h0,   0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'h00AB0041, 0, 32'h0};
    vecs[11] = '{1, 4'h0, 32'hC,   32'h0,        1, 32'h10,  1, 0, 1, 4'h0, 32'hC,   32'h0,        1, 0, 32'h0,        0, 32'h0};
    vecs[12] = '{0, 4'hF, 32'h0,   32'h12345678, 1, 32'h10,  0, 1, 1, 4'h0, 32'h10,  32'h0,        0, 1, 32'h3,        0, 32'h0};
    vecs[13] = '{0, 4'h0, 32'h0,   32'h0,        0, 32'h0,   0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0,        1, 32'h4};

    reset1 = 1'b1;
    reset2 = 1'b1;
    bus1.d_req = 1'b1; bus1.d_we = '0; bus1.d_addr = 32'h40; bus1.d_wdata = '0;
    bus1.f_req = 1'b1; bus1.f_addr = 32'h80;
    bus2.d_req = 1'b0; bus2.d_we = '0; bus2.d_addr = '0; bus2.d_wdata = '0;
    bus2.f_req = 1'b0; bus2.f_addr = '0;

    // Grants and port are held off while reset is high, even with requests
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.d_gnt",    32'(bus1.d_gnt),    32'h0);
    checkOutput("reset.f_gnt",    32'(bus1.f_gnt),    32'h0);
    checkOutput("reset.mem_en",   32'(bus1.mem_en),   32'h0);
    checkOutput("reset.d_rvalid", 32'(bus1.d_rvalid), 32'h0);
    checkOutput("reset.f_rvalid", 32'(bus1.f_rvalid), 32'h0);
    checkOutput("reset.d_rdata",  bus1.d_rdata,       32'h0);
    checkOutput("reset.f_rdata",  bus1.f_rdata,       32'h0);

    @(posedge clk);
    #1;
    reset1 = 1'b0;
    bus1.d_req = 1'b0;
    bus1.f_req = 1'b0;

    // Cycle-by-cycle table on the single-cycle-latency instance
    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d.d_gnt", i),    32'(bus1.d_gnt),         32'(vecs[i].e_d_gnt));
      checkOutput($sformatf("vec%0d.f_gnt", i),    32'(bus1.f_gnt),         32'(vecs[i].e_f_gnt));
      checkOutput($sformatf("vec%0d.mem_en", i),   32'(bus1.mem_en),        32'(vecs[i].e_mem_en));
      checkOutput($sformatf("vec%0d.mem_we", i),   32'(bus1.mem_we),        32'(vecs[i].e_mem_we));
      checkOutput($sformatf("vec%0d.mem_addr", i), bus1.mem_addr,           vecs[i].e_mem_addr);
      checkOutput($sformatf("vec%0d.mem_din", i),  bus1.mem_din,            vecs[i].e_mem_din);
      checkOutput($sformatf("vec%0d.stalled", i),  32'(bus1.fetch_stalled), 32'(vecs[i].e_stall));
      checkOutput($sformatf("vec%0d.d_rvalid", i), 32'(bus1.d_rvalid),      32'(vecs[i].e_d_rvalid));
      checkOutput($sformatf("vec%0d.d_rdata", i),  bus1.d_rdata,            vecs[i].e_d_rdata);
      checkOutput($sformatf("vec%0d.f_rvalid", i), 32'(bus1.f_rvalid),      32'(vecs[i].e_f_rvalid));
      checkOutput($sformatf("vec%0d.f_rdata", i),  bus1.f_rdata,            vecs[i].e_f_rdata);
    end

    // Six cycles of contention: data read of 0x20 (word 8) vs fetch of 0x40 (word 16)
    prev_d = 1'b0;
    prev_f = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      drive1(1'b1, 32'h20, 1'b1, 32'h40);
      @(negedge clk);
      exp_d = !(guard && c == 5);
      checkOutput($sformatf("cont%0d.d_gnt", c),    32'(bus1.d_gnt),         32'(exp_d));
      checkOutput($sformatf("cont%0d.f_gnt", c),    32'(bus1.f_gnt),         32'(!exp_d));
      checkOutput($sformatf("cont%0d.stalled", c),  32'(bus1.fetch_stalled), 32'(exp_d));
      checkOutput($sformatf("cont%0d.mem_addr", c), bus1.mem_addr,           exp_d ? 32'h20 : 32'h40);
      checkOutput($sformatf("cont%0d.d_rvalid", c), 32'(bus1.d_rvalid),      32'(prev_d));
      checkOutput($sformatf("cont%0d.f_rvalid", c), 32'(bus1.f_rvalid),      32'(prev_f));
      checkOutput($sformatf("cont%0d.d_rdata", c),  bus1.d_rdata,            prev_d ? 32'd8 : 32'd0);
      checkOutput($sformatf("cont%0d.f_rdata", c),  bus1.f_rdata,            prev_f ? 32'd16 : 32'd0);
      prev_d = exp_d;
      prev_f = !exp_d;
    end
    drive1(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("cont_tail.d_rvalid", 32'(bus1.d_rvalid), 32'h1);
    checkOutput("cont_tail.d_rdata",  bus1.d_rdata,       32'd8);
    checkOutput("cont_tail.mem_en",   32'(bus1.mem_en),   32'h0);

    // Two-cycle latency: read of 0xC returns word 3 two cycles after its grant
    @(posedge clk);
    #1;
    reset2 = 1'b0;
    @(posedge clk);
    #1;
    bus2.d_req = 1'b1; bus2.d_addr = 32'hC;
    @(negedge clk);
    checkOutput("lat2.d_gnt", 32'(bus2.d_gnt), 32'h1);
    @(posedge clk);
    #1;
    bus2.d_req = 1'b0;
    @(negedge clk);
    checkOutput("lat2.early_rvalid", 32'(bus2.d_rvalid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("lat2.d_rvalid", 32'(bus2.d_rvalid), 32'h1);
    checkOutput("lat2.d_rdata",  bus2.d_rdata,       32'h3);
    checkOutput("lat2.f_rvalid", 32'(bus2.f_rvalid), 32'h0);

    // Reset on the edge after a read grant discards the in-flight response
    @(posedge clk);
    #1;
    bus2.d_req = 1'b1; bus2.d_addr = 32'h14;
    @(negedge clk);
    checkOutput("rstmid.d_gnt", 32'(bus2.d_gnt), 32'h1);
    @(posedge clk);
    #1;
    reset2 = 1'b1;
    bus2.d_req = 1'b0;
    bus2.f_req = 1'b1; bus2.f_addr = 32'h8;
    @(negedge clk);
    checkOutput("rstmid.f_gnt_in_reset",  32'(bus2.f_gnt),  32'h0);
    checkOutput("rstmid.mem_en_in_reset", 32'(bus2.mem_en), 32'h0);
    @(posedge clk);
    #1;
    reset2 = 1'b0;
    bus2.f_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rstmid%0d.d_rvalid", k), 32'(bus2.d_rvalid), 32'h0);
      checkOutput($sformatf("rstmid%0d.d_rdata", k),  bus2.d_rdata,       32'h0);
      checkOutput($sformatf("rstmid%0d.f_rvalid", k), 32'(bus2.f_rvalid), 32'h0);
      checkOutput($sformatf("rstmid%0d.f_rdata", k),  bus2.f_rdata,       32'h0);
      @(posedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/hubris_mem_arbiter.md
# hubris_mem_arbiter

Two-requester arbiter that shares one single-port synchronous memory between the Hubris data path (loads/stores from the MEM stage) and the instruction fetch unit. It makes the per-cycle grant decision and drives the memory port from the winner. Registered tags route each read response back to its owner after the memory's fixed read latency. It sits between the core's two memory ports and one BRAM port, so the core can run on single-port memory configurations.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; byte-enable width is DATA_WIDTH/8
- READ_LATENCY, 1, memory read latency in cycles; legal values are 1 or 2
- MAX_DATA_STREAK, 4, maximum consecutive data grants while fetch waits (guard builds only)

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- d_req  in  1  data request; held with its payload until d_gnt
- d_we  in  DATA_WIDTH/8  byte write enables; 0 means read
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data, already lane-aligned
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  data read response valid
- d_rdata  out  DATA_WIDTH  data read response
- f_req  in  1  fetch request; held until f_gnt
- f_addr  in  ADDR_WIDTH  fetch address
- f_gnt  out  1  fetch accepted this cycle (combinational)
- f_rvalid  out  1  fetch response valid
- f_rdata  out  DATA_WIDTH  fetched instruction
- mem_en  out  1  memory enable
- mem_we  out  DATA_WIDTH/8  memory byte write enables
- mem_addr  out  ADDR_WIDTH  memory address
- mem_din  out  DATA_WIDTH  memory write data
- mem_dout  in  DATA_WIDTH  memory read data
- fetch_stalled  out  1  f_req high and f_gnt low this cycle

## Operation
- At most one grant per cycle. Both grants are forced to 0 while reset is high.
- Default priority: data beats fetch.
- The winner's fields drive the memory port combinationally:
  - data winner: mem_en=1, mem_we=d_we, mem_addr=d_addr, mem_din=d_wdata
  - fetch winner: mem_en=1, mem_we=0, mem_addr=f_addr, mem_din=0
  - no grant: mem_en=0, mem_we=0, mem_addr=0, mem_din=0
- Every granted read (data with d_we=0, or any fetch) pushes an owner tag (valid bit plus owner ID) into a READ_LATENCY-deep shift register.
- Writes push a tag with valid=0 and never produce an rvalid.
- At the tag pipe output, the owning side gets rvalid=1 and rdata=mem_dout. The non-owning rdata is held at 0.
- Each requester must hold its payload stable while its req is high and its gnt is low. The arbiter does not check this.

## Timing
- Grant: same cycle as the request, combinational from req inputs and registered state.
- Read response: *_rvalid asserts exactly READ_LATENCY cycles after the grant edge. Throughput is one access per cycle.
- Reset values: d_rvalid=f_rvalid=0, d_rdata=f_rdata=0, tag pipe all invalid, streak counter=0. During reset, d_gnt=f_gnt=0 and mem_en=0.
- Reset mid-operation: in-flight tags are discarded, so no rvalid is issued for reads granted before reset.
- Simultaneous requests: see Configuration.
- fetch_stalled asserts only when fetch actually loses arbitration.

## Configuration
- Macro: HUBRIS_ARB_STARVATION_GUARD_EN.
- Defined:
  - A saturating streak counter, width clog2(MAX_DATA_STREAK+1), increments on each data grant while f_req=1.
  - It clears on any fetch grant, or in any cycle where f_req=0.
  - When the counter equals MAX_DATA_STREAK and f_req=1, fetch wins over a pending d_req, and the counter clears on that edge.
- Undefined: strict data priority; the counter and the parameter are unused and no counter logic is synthesized.

## Structure
- Shared package hubris_mem_pkg holds:
  - owner enum {OWNER_DATA, OWNER_FETCH}
  - the tag struct {valid, owner}
  - the BYTE_EN_WIDTH constant
- One sub-module, hubris_mem_resp_tracker, holds the tag shift register and the rvalid/rdata steering. The top level keeps the grant logic and the streak counter.

## Test plan
- Fetch only: f_req=1 at addresses 0x0, 0x4, 0x8 on consecutive cycles, READ_LATENCY=1 -> f_gnt=1 each cycle; f_rvalid on cycles +1, +2, +3 carrying mem words 0, 1, 2; d_rvalid stays 0.
- Contention without guard: d_req and f_req both high for 6 cycles -> d_gnt=1 all 6 cycles, f_gnt=0, fetch_stalled=1 throughout.
- Contention with guard, MAX_DATA_STREAK=4: same stimulus -> data granted on cycles 1–4, fetch granted on cycle 5, data granted on cycle 6.
- Write then read: data writes 0xDEADBEEF to 0x100 with d_we=4'hF, then reads 0x100 -> no d_rvalid for the write; the read returns 0xDEADBEEF one cycle after its grant.
- Byte store: d_we=4'b0100 to 0x104, mem_din=0x00AB0000 -> mem_we=4'b0100; a later read of 0x104 shows only byte 2 changed.
- Reset mid-read: read granted, reset asserted on the next edge, READ_LATENCY=2 -> no rvalid is issued; after reset, all outputs are at their reset values.
